// File: rtl/bcd_bin_converter_if.sv
// Handshake and data bus of the BCD/binary converter.
// The master issues start/mode/data_in; the slave returns the status and the result.
interface bcd_bin_converter_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  start;
  logic                  mode;
  logic [4*DIGITS-1:0]   data_in;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [4*DIGITS-1:0]   data_out;

  modport master (
    output start, mode, data_in,
    input  busy, done, err, data_out
  );

  modport slave (
    input  start, mode, data_in,
    output busy, done, err, data_out
  );
endinterface

// File: rtl/bcd_bin_converter.sv
// Sequential packed-BCD <-> unsigned binary converter with a one-shot start/done handshake.
// Mode 0: multiply-by-10 accumulate, MSD first. Mode 1: double-dabble, one bit per cycle.
module bcd_bin_converter #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input logic               clk,
  input logic               rst_n,
  bcd_bin_converter_if.slave bus
);

  localparam int unsigned DataW = 4 * DIGITS;
  localparam int unsigned CntW  = $clog2(BIN_W + 1);

  function automatic logic [DataW-1:0] pow10_f(input int unsigned n);
    logic [DataW-1:0] r;
    r = DataW'(1);
    for (int unsigned i = 0; i < n; i++) begin
      r = (r << 3) + (r << 1);
    end
    return r;
  endfunction

  // First value that does not fit in DIGITS decimal digits.
  localparam logic [DataW-1:0] Limit = pow10_f(DIGITS);

  if (BIN_W > DataW) begin : g_bad_width
    $error("BIN_W must not exceed 4*DIGITS");
  end
  if (BIN_W < DataW && ((Limit - DataW'(1)) >> BIN_W) != '0) begin : g_bad_range
    $error("BIN_W too small to hold 10^DIGITS-1");
  end

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e            state_q;
  logic              mode_q;
  logic [DataW-1:0]  op_q;
  logic [BIN_W-1:0]  acc_q;
  logic [DataW-1:0]  bcd_q;
  logic [CntW-1:0]   cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [DataW-1:0]  dout_q;

  logic              digit_bad;
  logic              range_bad;
  logic [BIN_W-1:0]  acc_nxt;
  logic [DataW-1:0]  bcd_adj;
  logic [DataW-1:0]  bcd_nxt;
  logic              last_iter;

  always_comb begin
    digit_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bus.data_in[4*i +: 4] > 4'd9) digit_bad = 1'b1;
    end
  end

  assign range_bad = (bus.data_in >= Limit);

  // acc*10 as two shifts; cannot overflow once every digit has passed the pre-check.
  assign acc_nxt = (acc_q << 3) + (acc_q << 1) + BIN_W'(op_q[DataW-1 -: 4]);

  always_comb begin
    bcd_adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                     : bcd_q[4*i +: 4];
    end
  end

  assign bcd_nxt   = {bcd_adj[DataW-2:0], op_q[BIN_W-1]};
  assign last_iter = mode_q ? (cnt_q == CntW'(BIN_W - 1)) : (cnt_q == CntW'(DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      op_q    <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            mode_q <= bus.mode;
            op_q   <= bus.data_in;
            acc_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if ((!bus.mode && digit_bad) || (bus.mode && range_bad)) begin
              state_q <= StFin;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (mode_q) begin
            bcd_q <= bcd_nxt;
            op_q  <= op_q << 1;
          end else begin
            acc_q <= acc_nxt;
            op_q  <= op_q << 4;
          end
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            dout_q  <= mode_q ? bcd_nxt : DataW'(acc_nxt);
            err_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StFin: begin
          // Error path holds one extra cycle so done lands two cycles after start.
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(1)) begin
            dout_q  <= '0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.data_out = dout_q;

endmodule

// File: tb/tb_bcd_bin_converter.sv
// Randomised scoreboard bench for bcd_bin_converter (DIGITS=4, BIN_W=14).
module tb_bcd_bin_converter;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned BIN_W  = 14;
  localparam int unsigned DW     = 4 * DIGITS;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            lat;
    int            c0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];
  exp_t mon_x;
  logic [DW-1:0] hold_data = '0;
  logic          hold_err = 1'b0;

  bcd_bin_converter_if #(.DIGITS(DIGITS)) bus ();

  bcd_bin_converter #(
    .DIGITS(DIGITS),
    .BIN_W (BIN_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: plain decimal arithmetic on the operand.
  task automatic model(input logic m, input logic [DW-1:0] d, output exp_t x);
    int v;
    int lim;
    bit bad;
    v = 0;
    bad = 0;
    lim = 1;
    for (int i = 0; i < int'(DIGITS); i++) lim = lim * 10;
    if (!m) begin
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
        int dig;
        dig = int'((d >> (4 * i)) & 15);
        if (dig > 9) bad = 1;
        v = v * 10 + dig;
      end
      x.err  = bad;
      x.data = bad ? '0 : DW'(v);
      x.lat  = bad ? 2 : int'(DIGITS);
    end else begin
      int n;
      logic [DW-1:0] r;
      n = int'(d);
      r = '0;
      if (n >= lim) begin
        bad = 1;
      end else begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          r = r | (DW'(n % 10) << (4 * i));
          n = n / 10;
        end
      end
      x.err  = bad;
      x.data = r;
      x.lat  = bad ? 2 : int'(BIN_W);
    end
  endtask

  task automatic issue(input logic m, input logic [DW-1:0] d);
    int   w;
    exp_t x;
    w = 0;
    @(negedge clk);
    while (bus.busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (bus.busy) begin
      check("wait_idle", 32'(bus.busy), 32'd0);
      return;
    end
    bus.start   = 1'b1;
    bus.mode    = m;
    bus.data_in = d;
    @(posedge clk);
    #1;
    model(m, d, x);
    x.c0 = cyc;
    sb.push_back(x);
    check("busy_rise", 32'(bus.busy), 32'd1);
    bus.start   = 1'b0;
    bus.mode    = 1'($urandom);
    bus.data_in = DW'($urandom);
  endtask

  // Pulse start while a conversion runs; it must be ignored.
  task automatic poke_busy();
    @(negedge clk);
    if (bus.busy) begin
      bus.start   = 1'b1;
      bus.mode    = 1'($urandom);
      bus.data_in = DW'($urandom);
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'(bus.done), 32'd0);
        end else begin
          mon_x = sb.pop_front();
          check("data_out", 32'(bus.data_out), 32'(mon_x.data));
          check("err", 32'(bus.err), 32'(mon_x.err));
          check("latency", 32'(cyc - mon_x.c0), 32'(mon_x.lat));
          hold_data = mon_x.data;
          hold_err  = mon_x.err;
        end
      end else begin
        check("hold_data", 32'(bus.data_out), 32'(hold_data));
        check("hold_err", 32'(bus.err), 32'(hold_err));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic          m;
    bus.start   = 1'b0;
    bus.mode    = 1'b0;
    bus.data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_data", 32'(bus.data_out), 32'd0);
    rst_n = 1'b1;

    // Directed cases, back-to-back so start lands in the done cycle.
    issue(1'b0, 16'h1234);
    issue(1'b0, 16'h9999);
    issue(1'b1, 16'h270F);
    issue(1'b1, 16'h0000);
    issue(1'b0, 16'h0000);
    issue(1'b0, 16'h12A4);
    issue(1'b0, 16'h0042);
    issue(1'b1, 16'h2710);
    issue(1'b1, 16'h0001);
    issue(1'b0, 16'hF000);
    poke_busy();
    issue(1'b1, 16'h1F40);
    poke_busy();
    drain();

    // Reset during iteration 2 of a mode-0 run.
    issue(1'b0, 16'h5678);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_err", 32'(bus.err), 32'd0);
    check("midrst_data", 32'(bus.data_out), 32'd0);
    sb.delete();
    hold_data = '0;
    hold_err  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(1'b0, 16'h5678);
    drain();

    // Randomised traffic.
    for (int k = 0; k < 200; k++) begin
      m = 1'($urandom);
      if (!m) begin
        for (int i = 0; i < int'(DIGITS); i++) d[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 7) == 0) d[4*$urandom_range(0, DIGITS-1) +: 4] =
            4'($urandom_range(10, 15));
      end else begin
        d = ($urandom_range(0, 7) == 0) ? DW'($urandom_range(10000, 65535))
                                        : DW'($urandom_range(0, 9999));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(m, d);
      if ($urandom_range(0, 4) == 0) poke_busy();
    end
    drain();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
